// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined) feeding a show-ahead receive FIFO.
// uart_in is registered and reads 8'h00 whenever the FIFO is empty.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       uart_rdreq,
  output logic       uart_empty,
  output logic [7:0] uart_in,
  output logic       uart_full,
  output logic       overflow,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_MID  = CW'(CLKS_PER_BIT / 2);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  logic          rx_meta, rxs;
  logic [2:0]    state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          baud_last, stop_hit, push;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  assign baud_last = (baud == BAUD_LAST);
  assign stop_hit  = (state == ST_STOP) && baud_last;
  assign push      = stop_hit && rxs && !par_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          baud <= '0;
          if (!rxs) state <= ST_START;
        end
        ST_START: begin
          if (baud == BAUD_MID) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            baud <= baud + CW'(1);
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud    <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= ST_PARITY;
`else
            if (bit_idx == 3'd7) state <= ST_STOP;
`endif
          end else begin
            baud <= baud + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (baud_last) begin
            baud  <= '0;
            state <= ST_STOP;
          end else begin
            baud <= baud + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (baud_last) begin
            baud  <= '0;
            state <= rxs ? ST_IDLE : ST_BREAK;
          end else begin
            baud <= baud + CW'(1);
          end
        end
        ST_BREAK: if (rxs) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_hit;
  assign par_hit = (state == ST_PARITY) && baud_last;

  // Even parity: data bits XOR parity bit must be zero; cleared at each new frame.
  always_ff @(posedge clk) begin
    if (rst || state == ST_START) par_bad <= 1'b0;
    else if (par_hit)             par_bad <= ^{shreg, rxs};
  end

  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else if ((stop_hit && !rxs) || (par_hit && ^{shreg, rxs})) frame_err <= 1'b1;
  end
`else
  assign par_bad = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else if (stop_hit && !rxs) frame_err <= 1'b1;
  end
`endif

  // Receive FIFO
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [ADDR_W:0]   count, cnt_nxt;
  logic              pop, wr_en;

  assign uart_empty = (count == '0);
  assign uart_full  = (count == (ADDR_W+1)'(DEPTH));
  assign pop        = uart_rdreq && !uart_empty;
  assign wr_en      = push && (!uart_full || pop);

  always_comb begin
    rd_nxt  = pop ? rd_ptr + ADDR_W'(1) : rd_ptr;
    cnt_nxt = count;
    case ({wr_en, pop})
      2'b10:   cnt_nxt = count + (ADDR_W+1)'(1);
      2'b01:   cnt_nxt = count - (ADDR_W+1)'(1);
      default: cnt_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      uart_in  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (push && uart_full && !pop) overflow <= 1'b1;
      // Head register bypasses the array when the new head is written this same edge.
      if (cnt_nxt == '0)                 uart_in <= 8'h00;
      else if (wr_en && wr_ptr == rd_nxt) uart_in <= shreg;
      else                               uart_in <= mem[rd_nxt];
    end
  end
endmodule
